out_bram_arbiter: RTL and testbench

Shares one output-BRAM write port between NUM_REQ flatten engines. Each engine sends a 32x32 softmax result as a burst of BURST_LEN single-word writes. The arbiter grants one requester for a whole burst, using round-robin order. It registers the owner's writes onto the BRAM port, with the owner index prepended to the local address to select a bank. The block sits between the per-lane output flatten stages and the shared result BRAM; each requester's grant drives that flatten's i_valid.

---
 rtl/out_bram_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/out_bram_arbiter.sv | 118 +++++++++++
 tb/tb_out_bram_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_bram_pkg.sv
// Shared types and helpers for the output-BRAM write-port arbiter.
package out_bram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int BURST_LEN_DEFAULT = 1024;

  // The owner index becomes the bank select above the requester's local address.
  function automatic logic [31:0] bank_addr(input logic [31:0] owner,
                                            input logic [31:0] local_addr,
                                            input int          addr_width);
    return (owner << addr_width) | local_addr;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-one finder: lowest set request at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_BITS-1:0] rr_ptr,
  output logic [REQ_BITS-1:0] idx,
  output logic                valid
);

  logic [REQ_BITS-1:0] pos;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  // Scan from the farthest offset down so the closest hit to rr_ptr wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = REQ_BITS'(wrap_idx(int'(rr_ptr), k));
      if (req[pos]) begin
        idx   = pos;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_bram_arbiter.sv
// Round-robin, burst-granular arbiter sharing one result-BRAM write port among flatten engines.
module out_bram_arbiter
  import out_bram_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BIT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = BURST_LEN_DEFAULT,
  parameter int REQ_BITS   = $clog2(NUM_REQ)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_REQ-1:0]                   i_req,
  output logic [NUM_REQ-1:0]                   o_grant,
  input  logic [NUM_REQ-1:0]                   i_wr_en,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0]    i_wr_data,
  input  logic [NUM_REQ-1:0]                   i_done,
  output logic                                 o_bram_we,
  output logic [REQ_BITS+ADDR_WIDTH-1:0]       o_bram_addr,
  output logic [BIT_WIDTH-1:0]                 o_bram_data,
  output logic [REQ_BITS-1:0]                  o_owner,
  output logic                                 o_busy,
  output logic [NUM_REQ-1:0]                   o_burst_done,
  output logic                                 o_err
);

  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int BADDR_W = REQ_BITS + ADDR_WIDTH;

  arb_state_t          state_q, state_d;
  logic [REQ_BITS-1:0] owner_q, rr_ptr_q, pick_idx, next_ptr;
  logic                pick_valid;
  logic [CNT_W-1:0]    wr_count_q;
  logic [NUM_REQ-1:0]  owner_onehot;
  logic                owner_wr, owner_done, owner_req, count_full, stray_wr;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .REQ_BITS (REQ_BITS)
  ) u_rr_pick (
    .req    (i_req),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Any strobe outside the owner's grant window is a protocol violation.
  always_comb begin
    owner_onehot           = '0;
    owner_onehot[owner_q]  = 1'b1;
    owner_wr               = i_wr_en[owner_q];
    owner_done             = i_done[owner_q];
    owner_req              = i_req[owner_q];
    count_full             = (wr_count_q == CNT_W'(BURST_LEN));
    next_ptr               = (owner_q == REQ_BITS'(NUM_REQ - 1)) ? '0 : owner_q + REQ_BITS'(1);
    stray_wr               = (state_q == GRANT) ? |(i_wr_en & ~owner_onehot) : |i_wr_en;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   if (owner_done || !owner_req) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Write path, counter, bank pointer and sticky error all advance with the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      wr_count_q   <= '0;
      o_bram_we    <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_data  <= '0;
      o_burst_done <= '0;
      o_err        <= 1'b0;
    end else begin
      o_bram_we    <= 1'b0;
      o_burst_done <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) owner_q <= pick_idx;
        end
        GRANT: begin
          if (owner_wr && !count_full) begin
            o_bram_we   <= 1'b1;
            o_bram_addr <= BADDR_W'(bank_addr(32'(owner_q), 32'(i_wr_addr[owner_q]), ADDR_WIDTH));
            o_bram_data <= i_wr_data[owner_q];
            wr_count_q  <= wr_count_q + CNT_W'(1);
          end
          if (owner_wr && count_full) o_err <= 1'b1;
          if (owner_done)      o_burst_done <= owner_onehot;
          else if (!owner_req) o_err        <= 1'b1;
        end
        RELEASE: begin
          rr_ptr_q   <= next_ptr;
          wr_count_q <= '0;
        end
        default: ;
      endcase
      if (stray_wr) o_err <= 1'b1;
    end
  end

  assign o_grant = (state_q == GRANT) ? owner_onehot : '0;
  assign o_owner = owner_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_out_bram_arbiter.sv
// Self-checking bench for out_bram_arbiter: vector table, directed corner cases, randomized run vs. a reference model.
module tb_out_bram_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int BL = 1024;
  localparam int RB = 2;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic [N-1:0]           i_req, o_grant, i_wr_en, i_done, o_burst_done;
  logic [N-1:0][AW-1:0]   i_wr_addr;
  logic [N-1:0][DW-1:0]   i_wr_data;
  logic                   o_bram_we, o_busy, o_err;
  logic [RB+AW-1:0]       o_bram_addr;
  logic [DW-1:0]          o_bram_data;
  logic [RB-1:0]          o_owner;

  out_bram_arbiter #(
    .NUM_REQ(N), .BIT_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .REQ_BITS(RB)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_grant(o_grant),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_done(i_done),
    .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr), .o_bram_data(o_bram_data),
    .o_owner(o_owner), .o_busy(o_busy), .o_burst_done(o_burst_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int    n_total = 0;
  int    n_pass  = 0;
  string tag     = "init";

  // Reference model: 0 = no owner, 1 = owner holds the port, 2 = hand-back cycle.
  int           m_state, m_owner, m_ptr, m_count;
  bit           m_err;
  logic [N-1:0] e_grant, e_bd;
  bit           e_we;
  int           e_addr, e_data;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] wr_en;
    logic [N-1:0] done;
    logic [N-1:0] exp_grant;
    bit           exp_busy;
    int           exp_owner;
    bit           exp_we;
    int           exp_addr;
    logic [N-1:0] exp_bd;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s/%s: actual=%0h required=%0h", tag, name, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_owner = 0; m_ptr = 0; m_count = 0; m_err = 0;
    e_grant = '0; e_bd = '0; e_we = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_edge();
    int prev_state, prev_owner;
    prev_state = m_state;
    prev_owner = m_owner;
    e_we = 0;
    e_bd = '0;
    for (int i = 0; i < N; i++)
      if (i_wr_en[i] && !(prev_state == 1 && i == prev_owner)) m_err = 1;
    if (prev_state == 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (i_req[c]) begin
          m_owner = c;
          m_state = 1;
          break;
        end
      end
    end else if (prev_state == 1) begin
      if (i_wr_en[m_owner]) begin
        if (m_count < BL) begin
          e_we   = 1;
          e_addr = m_owner * (1 << AW) + int'(i_wr_addr[m_owner]);
          e_data = int'(i_wr_data[m_owner]);
          m_count++;
        end else m_err = 1;
      end
      if (i_done[m_owner]) begin
        e_bd[m_owner] = 1'b1;
        m_state = 2;
      end else if (!i_req[m_owner]) begin
        m_err = 1;
        m_state = 2;
      end
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_count = 0;
      m_state = 0;
    end
    e_grant = '0;
    if (m_state == 1) e_grant[m_owner] = 1'b1;
  endtask

  task automatic check_output();
    check("grant", 32'(o_grant), 32'(e_grant));
    check("bram_we", 32'(o_bram_we), 32'(e_we));
    if (e_we) begin
      check("bram_addr", 32'(o_bram_addr), e_addr);
      check("bram_data", 32'(o_bram_data), e_data);
    end
    check("busy", 32'(o_busy), 32'(m_state != 0));
    check("owner", 32'(o_owner), m_owner);
    check("burst_done", 32'(o_burst_done), 32'(e_bd));
    check("err", 32'(o_err), 32'(m_err));
  endtask

  task automatic apply_stimulus();
    model_edge();
    @(posedge i_clk);
    #1;
    check_output();
  endtask

  task automatic clear_inputs();
    i_req = '0; i_wr_en = '0; i_done = '0; i_wr_addr = '0; i_wr_data = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check_output();
  endtask

  task automatic wait_grant(output int lane);
    lane = -1;
    for (int t = 0; t < 8; t++) begin
      apply_stimulus();
      if (o_grant != '0) begin
        for (int i = 0; i < N; i++) if (o_grant[i]) lane = i;
        break;
      end
    end
    if (lane < 0) begin
      n_total++;
      $display("[TB] FAIL %s/grant_timeout: actual=none required=grant within 8 cycles", tag);
    end
  endtask

  task automatic run_burst(input int lane, input int n, input bit with_done);
    if (lane < 0) return;
    for (int i = 0; i < n; i++) begin
      i_wr_en[lane]   = 1'b1;
      i_wr_addr[lane] = AW'(i);
      i_wr_data[lane] = DW'($urandom);
      i_done[lane]    = with_done && (i == n - 1);
      apply_stimulus();
    end
    i_wr_en[lane] = 1'b0;
    i_done[lane]  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int lane, cnt, gap;
    int order[5];

    tbl[0] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0,     4'b0000};
    tbl[1] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2, 1, 'h803, 4'b0000};
    tbl[2] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 1, 2, 1, 'h803, 4'b0100};
    tbl[3] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 0,     4'b0000};
    tbl[4] = '{4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0,     4'b0000};
    tbl[5] = '{4'b0011, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0,     4'b0001};
    tbl[6] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0,     4'b0000};
    tbl[7] = '{4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0,     4'b0000};

    i_rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    tag = "reset";
    check("grant", 32'(o_grant), 0);
    check("err", 32'(o_err), 0);
    check("owner", 32'(o_owner), 0);
    i_rst_n = 1'b1;

    tag = "table";
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < N; l++) begin
        i_wr_addr[l] = AW'(l + 1);
        i_wr_data[l] = DW'(16'h0011 * (l + 1));
      end
      i_req = tbl[i].req; i_wr_en = tbl[i].wr_en; i_done = tbl[i].done;
      apply_stimulus();
      check($sformatf("v%0d_grant", i), 32'(o_grant), 32'(tbl[i].exp_grant));
      check($sformatf("v%0d_busy", i), 32'(o_busy), 32'(tbl[i].exp_busy));
      check($sformatf("v%0d_owner", i), 32'(o_owner), tbl[i].exp_owner);
      check($sformatf("v%0d_we", i), 32'(o_bram_we), 32'(tbl[i].exp_we));
      if (tbl[i].exp_we) check($sformatf("v%0d_addr", i), 32'(o_bram_addr), tbl[i].exp_addr);
      check($sformatf("v%0d_bd", i), 32'(o_burst_done), 32'(tbl[i].exp_bd));
      check($sformatf("v%0d_err", i), 32'(o_err), 0);
    end

    tag = "single";
    do_reset();
    i_req[2] = 1'b1;
    apply_stimulus();
    check("grant_rise", 32'(o_grant), 32'h4);
    for (int a = 0; a < BL; a++) begin
      i_wr_en[2] = 1'b1; i_wr_addr[2] = AW'(a); i_wr_data[2] = DW'(a);
      i_done[2] = (a == BL - 1);
      apply_stimulus();
      if (a == 0)      check("first_addr", 32'(o_bram_addr), 32'h800);
      if (a == BL - 1) check("last_addr", 32'(o_bram_addr), 32'hBFF);
    end
    check("done_pulse", 32'(o_burst_done), 32'h4);
    clear_inputs();
    apply_stimulus();
    check("clean_err", 32'(o_err), 0);

    tag = "all_four";
    do_reset();
    order = '{0, 1, 2, 3, 0};
    i_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(lane);
      check($sformatf("order%0d", g), lane, order[g]);
      run_burst(lane, 3, 1);
    end

    tag = "gap";
    do_reset();
    i_req = 4'b0001;
    wait_grant(lane);
    for (int i = 0; i < 4; i++) begin
      i_wr_en[0] = 1'b1; i_wr_addr[0] = AW'(i);
      if (i == 1) i_req[1] = 1'b1;
      i_done[0] = (i == 3);
      apply_stimulus();
      if (i < 3) check("no_preempt", 32'(o_grant), 32'h1);
    end
    i_wr_en = '0; i_done = '0; i_req[0] = 1'b0;
    gap = (o_grant == '0) ? 1 : 0;
    for (int t = 0; t < 8; t++) begin
      apply_stimulus();
      if (o_grant != '0) break;
      gap++;
    end
    check("gap_cycles", gap, 2);
    check("gap_next", 32'(o_grant), 32'h2);

    tag = "abort";
    do_reset();
    i_req = 4'b1000;
    wait_grant(lane);
    i_req[0] = 1'b1; i_req[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      i_wr_en[3] = 1'b1; i_wr_addr[3] = AW'(i); i_wr_data[3] = DW'($urandom);
      apply_stimulus();
      cnt += int'(o_bram_we);
    end
    i_wr_en = '0; i_req[3] = 1'b0;
    apply_stimulus();
    cnt += int'(o_bram_we);
    check("abort_writes", cnt, 10);
    check("abort_err", 32'(o_err), 1);
    check("abort_no_done", 32'(o_burst_done), 0);
    wait_grant(lane);
    check("abort_next", lane, 0);

    tag = "stray";
    do_reset();
    i_req = 4'b0001;
    wait_grant(lane);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      i_wr_en[0] = 1'b1; i_wr_addr[0] = AW'(i); i_wr_data[0] = DW'(i + 100);
      i_wr_en[1] = (i == 2); i_wr_addr[1] = AW'(10'h3FF);
      apply_stimulus();
      cnt += int'(o_bram_we);
      check("owner_addr", 32'(o_bram_addr), i);
      if (i == 2) check("stray_err", 32'(o_err), 1);
    end
    check("stray_cnt", cnt, 6);
    i_wr_en = '0; i_done[0] = 1'b1;
    apply_stimulus();
    i_done = '0;

    tag = "overflow";
    do_reset();
    i_req = 4'b0010;
    wait_grant(lane);
    for (int i = 0; i < BL + 1; i++) begin
      i_wr_en[1] = 1'b1; i_wr_addr[1] = AW'(i); i_wr_data[1] = DW'(i);
      apply_stimulus();
      if (i == BL - 1) begin
        check("last_ok_we", 32'(o_bram_we), 1);
        check("last_ok_err", 32'(o_err), 0);
      end
      if (i == BL) begin
        check("over_we", 32'(o_bram_we), 0);
        check("over_err", 32'(o_err), 1);
      end
    end
    i_wr_en = '0; i_done[1] = 1'b1;
    apply_stimulus();
    i_done = '0;
    wait_grant(lane);
    check("regrant", lane, 1);
    i_wr_en[1] = 1'b1; i_wr_addr[1] = AW'(7);
    apply_stimulus();
    check("pre_reset_we", 32'(o_bram_we), 1);
    i_rst_n = 1'b0;
    #1;
    tag = "async_reset";
    check("grant", 32'(o_grant), 0);
    check("bram_we", 32'(o_bram_we), 0);
    check("err", 32'(o_err), 0);
    check("busy", 32'(o_busy), 0);
    check("owner", 32'(o_owner), 0);
    model_reset();
    i_wr_en = '0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_req = 4'b0011;
    wait_grant(lane);
    check("ptr_after_reset", lane, 0);

    tag = "random";
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if (c % 300 == 299) do_reset();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 19) == 0) i_req[i] = ~i_req[i];
        i_wr_addr[i] = AW'($urandom);
        i_wr_data[i] = DW'($urandom);
      end
      i_wr_en = '0;
      i_done  = '0;
      if (m_state == 1) begin
        if ($urandom_range(0, 3) != 0)  i_wr_en[m_owner] = 1'b1;
        if ($urandom_range(0, 29) == 0) i_done[m_owner]  = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) i_wr_en[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 49) == 0)  i_done[$urandom_range(0, N - 1)]  = 1'b1;
      apply_stimulus();
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
